// File: rtl/add_serial.sv
// Multi-cycle add/subtract unit: ripples SLICE bits per clock through 1-bit
// full adders, LSB slice first, with valid/ready handshakes and C/V/Z flags.
module add_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] SMASK = WIDTH'({SLICE{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              carry_q;
  logic [CW-1:0]     count;
  logic              last;
  logic [31:0]       sh;
  logic [SLICE-1:0]  a_s, b_s, sum_s;
  logic [SLICE:0]    c;
  logic [WIDTH-1:0]  result_nxt;

  assign last = (count == CW'(N - 1));

  // One SLICE-wide ripple of full adders over the current slice.
  always_comb begin
    sh    = 32'(count) * 32'(SLICE);
    a_s   = SLICE'(a_q >> sh);
    b_s   = SLICE'(b_q >> sh);
    sum_s = '0;
    c     = '0;
    c[0]  = carry_q;
    for (int unsigned i = 0; i < SLICE; i++) begin
      sum_s[i]  = a_s[i] ^ b_s[i] ^ c[i];
      c[i + 1]  = (a_s[i] & b_s[i]) | (c[i] & (a_s[i] ^ b_s[i]));
    end
    result_nxt = (result & ~(SMASK << sh)) | (WIDTH'(sum_s) << sh);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = RUN;
      RUN:     if (last)                 state_nxt = DONE;
      DONE:    if (out_ready)            state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      count    <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          a_q     <= src1;
          b_q     <= sub ? ~src2 : src2;
          carry_q <= sub ? 1'b1 : cin;
          count   <= '0;
        end
        RUN: begin
          result  <= result_nxt;
          carry_q <= c[SLICE];
          count   <= count + CW'(1);
          // The last slice holds bit WIDTH-1, so c[SLICE-1] is the carry into the MSB.
          if (last) begin
            cout     <= c[SLICE];
            overflow <= c[SLICE] ^ c[SLICE-1];
            zero     <= (result_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_serial.sv
// Directed bench for add_serial: 8-bit/2-bit-slice unit for the main vectors,
// plus an 8-bit/8-bit-slice unit for the single-cycle latency/throughput case.
module tb_add_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       iv, ordy, sub, cin;
  logic [7:0] src1, src2;

  logic       ir0, ov0, co0, of0, z0;
  logic [7:0] r0;
  logic       ir1, ov1, co1, of1, z1;
  logic [7:0] r1;

  logic       iv0, iv1, ordy0, ordy1;
  logic       rir, rov, rco, rof, rz;
  logic [7:0] rres;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  assign iv0   = iv   & ~sel;
  assign iv1   = iv   &  sel;
  assign ordy0 = ordy & ~sel;
  assign ordy1 = ordy &  sel;
  assign rir   = sel ? ir1 : ir0;
  assign rov   = sel ? ov1 : ov0;
  assign rres  = sel ? r1  : r0;
  assign rco   = sel ? co1 : co0;
  assign rof   = sel ? of1 : of0;
  assign rz    = sel ? z1  : z0;

  add_serial #(.WIDTH(8), .SLICE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .sub(sub),
    .src1(src1), .src2(src2), .cin(cin), .out_valid(ov0), .out_ready(ordy0),
    .result(r0), .cout(co0), .overflow(of0), .zero(z0)
  );

  add_serial #(.WIDTH(8), .SLICE(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .sub(sub),
    .src1(src1), .src2(src2), .cin(cin), .out_valid(ov1), .out_ready(ordy1),
    .result(r1), .cout(co1), .overflow(of1), .zero(z1)
  );

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       co;
    logic       ovf;
    logic       z;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!rov && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic do_op(input vec_t v, input int lat);
    int k;
    @(negedge clk);
    sub = v.sub; src1 = v.a; src2 = v.b; cin = v.cin; iv = 1'b1;
    chk("in_ready_idle", 32'(rir), 32'd1);
    @(posedge clk); #1;
    iv = 1'b0;
    chk("in_ready_busy", 32'(rir), 32'd0);
    wait_valid(k);
    chk("latency", k, lat);
    chk("result", 32'(rres), 32'(v.res));
    chk("cout", 32'(rco), 32'(v.co));
    chk("overflow", 32'(rof), 32'(v.ovf));
    chk("zero", 32'(rz), 32'(v.z));
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("out_valid_drop", 32'(rov), 32'd0);
    chk("in_ready_after", 32'(rir), 32'd1);
  endtask

  initial begin
    int k;
    int last_t;
    int nres;
    //          sub  a      b      cin  res    co    ovf   z
    vecs[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h33, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};

    sel = 1'b0; iv = 1'b0; ordy = 1'b0; sub = 1'b0; cin = 1'b0;
    src1 = '0; src2 = '0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(rir), 32'd0);
    chk("rst_out_valid", 32'(rov), 32'd0);
    chk("rst_result", 32'(rres), 32'd0);
    chk("rst_flags", {29'd0, rco, rof, rz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_post_rst", 32'(rir), 32'd1);

    for (int i = 0; i < 9; i++) do_op(vecs[i], 4);

    // Backpressure: hold result while new operands wiggle on the input side.
    @(negedge clk);
    sub = 1'b0; src1 = 8'h10; src2 = 8'h20; cin = 1'b1; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    wait_valid(k);
    chk("bp_latency", k, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv = ~iv; sub = 1'b1; src1 = 8'(8'hC3 + i); src2 = 8'h11;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(rov), 32'd1);
      chk("bp_result", 32'(rres), 32'h31);
      chk("bp_flags", {29'd0, rco, rof, rz}, 32'd0);
      chk("bp_in_ready", 32'(rir), 32'd0);
    end
    @(negedge clk);
    sub = 1'b0; src1 = 8'hA5; src2 = 8'h5A; cin = 1'b0; iv = 1'b1; ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("bp_hs_out_valid", 32'(rov), 32'd0);
    chk("bp_hs_in_ready", 32'(rir), 32'd1);
    @(posedge clk); #1;
    iv = 1'b0;
    chk("bp_accept", 32'(rir), 32'd0);
    wait_valid(k);
    chk("bp_new_latency", k, 4);
    chk("bp_new_result", 32'(rres), 32'hFF);
    @(negedge clk); ordy = 1'b1;
    @(posedge clk); #1; ordy = 1'b0;

    // Reset after two RUN edges aborts the op.
    @(negedge clk);
    sub = 1'b0; src1 = 8'hFF; src2 = 8'h01; cin = 1'b0; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1 chk("abort_in_ready_rst", 32'(rir), 32'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1 chk("abort_in_ready", 32'(rir), 32'd1);
    nres = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rov) nres++;
    end
    chk("abort_no_valid", nres, 0);
    do_op(vecs[6], 4);

    // Single-cycle configuration.
    sel = 1'b1;
    do_op('{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1}, 1);
    do_op(vecs[3], 1);
    @(negedge clk);
    sub = 1'b0; src1 = 8'h80; src2 = 8'h80; cin = 1'b0; iv = 1'b1; ordy = 1'b1;
    nres = 0; last_t = -1;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      if (rov) begin
        if (last_t >= 0) chk("b2b_interval", t - last_t, 3);
        chk("b2b_result", 32'(rres), 32'h00);
        last_t = t;
        nres++;
      end
    end
    chk("b2b_count", nres, 3);
    iv = 1'b0; ordy = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hung expected finish");
    $fatal(1);
  end

endmodule
